// File: rtl/rf_writeback_pkg.sv
// rtl/rf_writeback_pkg.sv - shared core constants and types for the writeback stage
package rf_writeback_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_EX,
        SRC_HOLD,
        SRC_MEM,
        SRC_MD
    } src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - busy bits for destinations with long-latency results outstanding
module rf_scoreboard
    import rf_writeback_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  set_valid,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_valid,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    output logic [NUM_REGS-1:0]   busy
);

    logic [NUM_REGS-1:0] busy_next;

    // Set is applied after clear so a same-cycle reissue keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (clr_valid) begin
            busy_next[clr_rd] = 1'b0;
        end
        if (set_valid && set_rd != '0) begin
            busy_next[set_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/rf_writeback.sv
// rtl/rf_writeback.sv - merges execute, load and mul/div results into one registered regfile write
module rf_writeback
    import rf_writeback_pkg::src_e;
    import rf_writeback_pkg::SRC_NONE;
    import rf_writeback_pkg::SRC_EX;
    import rf_writeback_pkg::SRC_HOLD;
    import rf_writeback_pkg::SRC_MEM;
    import rf_writeback_pkg::SRC_MD;
    import rf_writeback_pkg::REG_ADDR_W;
    import rf_writeback_pkg::NUM_REGS;
#(
    parameter int XLEN = rf_writeback_pkg::XLEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]       ex_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    input  logic                  md_valid,
    output logic                  md_ready,
    input  logic [REG_ADDR_W-1:0] md_rd,
    input  logic [XLEN-1:0]       md_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic [NUM_REGS-1:0]   busy,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       rd_data,
    output logic                  we
);

    logic                  hold_valid;
    logic [REG_ADDR_W-1:0] hold_rd;
    logic [XLEN-1:0]       hold_data;

    src_e                  src;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;
    logic                  mem_acc;
    logic                  md_acc;
    logic                  long_wb;

    // Load readiness depends only on the hold register, so ex_valid never reaches mem_ready.
    assign mem_ready = rst_n && !flush && !hold_valid;
    assign md_ready  = rst_n && !flush && !ex_valid && !hold_valid && !mem_valid;
    assign mem_acc   = mem_valid && mem_ready;
    assign md_acc    = md_valid && md_ready;

    always_comb begin
        src      = SRC_NONE;
        sel_rd   = '0;
        sel_data = '0;
        if (ex_valid) begin
            src = SRC_EX;
        end else if (hold_valid && !flush) begin
            src = SRC_HOLD;
        end else if (mem_acc) begin
            src = SRC_MEM;
        end else if (md_acc) begin
            src = SRC_MD;
        end
        case (src)
            SRC_EX:   begin sel_rd = ex_rd;   sel_data = ex_data;   end
            SRC_HOLD: begin sel_rd = hold_rd; sel_data = hold_data; end
            SRC_MEM:  begin sel_rd = mem_rd;  sel_data = mem_data;  end
            SRC_MD:   begin sel_rd = md_rd;   sel_data = md_data;   end
            default:  begin sel_rd = '0;      sel_data = '0;        end
        endcase
    end

    assign long_wb = (src == SRC_HOLD) || (src == SRC_MEM) || (src == SRC_MD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_rd    <= '0;
            hold_data  <= '0;
            rd         <= '0;
            rd_data    <= '0;
            we         <= 1'b0;
        end else begin
            we <= (src != SRC_NONE) && (sel_rd != '0);
            if (src != SRC_NONE) begin
                rd      <= sel_rd;
                rd_data <= sel_data;
            end
            if (flush) begin
                hold_valid <= 1'b0;
            end else if (ex_valid && mem_acc) begin
                hold_valid <= 1'b1;
                hold_rd    <= mem_rd;
                hold_data  <= mem_data;
            end else if (src == SRC_HOLD) begin
                hold_valid <= 1'b0;
            end
        end
    end

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .set_valid (issue_valid),
        .set_rd    (issue_rd),
        .clr_valid (long_wb),
        .clr_rd    (sel_rd),
        .busy      (busy)
    );

endmodule

// File: tb/tb_rf_writeback.sv
// tb/tb_rf_writeback.sv - directed vector table plus randomized run against a queue-based model
module tb_rf_writeback;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            ex_valid;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_data;
    logic            mem_valid;
    logic            mem_ready;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            md_valid;
    logic            md_ready;
    logic [4:0]      md_rd;
    logic [XLEN-1:0] md_data;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [31:0]     busy;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
    logic            we;

    rf_writeback #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .ex_data     (ex_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .md_valid    (md_valid),
        .md_ready    (md_ready),
        .md_rd       (md_rd),
        .md_data     (md_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy        (busy),
        .rd          (rd),
        .rd_data     (rd_data),
        .we          (we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        ex_v;
        logic [4:0]  ex_rd;
        logic [63:0] ex_d;
        logic        mem_v;
        logic [4:0]  mem_rd;
        logic [63:0] mem_d;
        logic        md_v;
        logic [4:0]  md_rd;
        logic [63:0] md_d;
        logic        iss_v;
        logic [4:0]  iss_rd;
        logic        e_mr;
        logic        e_mdr;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [63:0] e_d;
        logic [31:0] e_busy;
    } vec_t;

    vec_t tbl[24];

    // Reference model state: pending deferred loads and the set of outstanding destinations.
    logic [4:0]  q_rd[$];
    logic [63:0] q_data[$];
    logic [31:0] m_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_check(input vec_t v);
        rst_n       = !v.rst;
        flush       = v.flush;
        ex_valid    = v.ex_v;
        ex_rd       = v.ex_rd;
        ex_data     = v.ex_d;
        mem_valid   = v.mem_v;
        mem_rd      = v.mem_rd;
        mem_data    = v.mem_d;
        md_valid    = v.md_v;
        md_rd       = v.md_rd;
        md_data     = v.md_d;
        issue_valid = v.iss_v;
        issue_rd    = v.iss_rd;
        #1;
        chk("mem_ready", {63'd0, mem_ready}, {63'd0, v.e_mr});
        chk("md_ready", {63'd0, md_ready}, {63'd0, v.e_mdr});
        @(posedge clk);
        @(negedge clk);
        chk("we", {63'd0, we}, {63'd0, v.e_we});
        if (v.e_we || v.rst) begin
            chk("rd", {59'd0, rd}, {59'd0, v.e_rd});
            chk("rd_data", rd_data, v.e_d);
        end
        chk("busy", {32'd0, busy}, {32'd0, v.e_busy});
    endtask

    task automatic model_step(inout vec_t v);
        logic        mr;
        logic        mdr;
        logic        wrote;
        logic        longw;
        logic [4:0]  wrd;
        logic [63:0] wd;
        if (v.rst) begin
            q_rd.delete();
            q_data.delete();
            m_busy  = '0;
            v.e_mr  = 1'b0;
            v.e_mdr = 1'b0;
            v.e_we  = 1'b0;
            v.e_rd  = '0;
            v.e_d   = '0;
            v.e_busy = '0;
            return;
        end
        mr    = !v.flush && q_rd.size() == 0;
        mdr   = mr && !v.ex_v && !v.mem_v;
        wrote = 1'b0;
        longw = 1'b0;
        wrd   = '0;
        wd    = '0;
        if (v.ex_v) begin
            wrote = 1'b1;
            wrd   = v.ex_rd;
            wd    = v.ex_d;
            if (v.mem_v && mr) begin
                q_rd.push_back(v.mem_rd);
                q_data.push_back(v.mem_d);
            end
        end else if (v.flush) begin
            wrote = 1'b0;
        end else if (q_rd.size() > 0) begin
            wrote = 1'b1;
            longw = 1'b1;
            wrd   = q_rd.pop_front();
            wd    = q_data.pop_front();
        end else if (v.mem_v && mr) begin
            wrote = 1'b1;
            longw = 1'b1;
            wrd   = v.mem_rd;
            wd    = v.mem_d;
        end else if (v.md_v && mdr) begin
            wrote = 1'b1;
            longw = 1'b1;
            wrd   = v.md_rd;
            wd    = v.md_d;
        end
        if (v.flush) begin
            q_rd.delete();
            q_data.delete();
            m_busy = '0;
        end else begin
            if (longw) m_busy[wrd] = 1'b0;
            if (v.iss_v && v.iss_rd != 0) m_busy[v.iss_rd] = 1'b1;
        end
        v.e_mr   = mr;
        v.e_mdr  = mdr;
        v.e_we   = wrote && wrd != 0;
        v.e_rd   = wrd;
        v.e_d    = wd;
        v.e_busy = m_busy;
    endtask

    initial begin
        //          rst flu ex rd  data      mem rd  data     md rd data     iss rd   mr mdr we rd data     busy
        tbl[0]  = '{1, 0, 0, 0, 0,        0, 0, 0,        0, 0, 0,       0, 0,    0, 0, 0, 0, 0,        0};
        tbl[1]  = '{0, 0, 1, 5, 'hDEAD,   0, 0, 0,        0, 0, 0,       0, 0,    1, 0, 1, 5, 'hDEAD,   0};
        tbl[2]  = '{0, 0, 1, 6, 'h66,     1, 7, 'h11,     0, 0, 0,       0, 0,    1, 0, 1, 6, 'h66,     0};
        tbl[3]  = '{0, 0, 0, 0, 0,        0, 0, 0,        0, 0, 0,       0, 0,    0, 0, 1, 7, 'h11,     0};
        tbl[4]  = '{0, 0, 0, 0, 0,        0, 0, 0,        0, 0, 0,       0, 0,    1, 1, 0, 0, 0,        0};
        tbl[5]  = '{0, 0, 0, 0, 0,        0, 0, 0,        0, 0, 0,       1, 3,    1, 1, 0, 0, 0,        'h8};
        tbl[6]  = '{0, 0, 0, 0, 0,        0, 0, 0,        0, 0, 0,       0, 0,    1, 1, 0, 0, 0,        'h8};
        tbl[7]  = '{0, 0, 0, 0, 0,        0, 0, 0,        1, 3, 'h33,    0, 0,    1, 1, 1, 3, 'h33,     0};
        tbl[8]  = '{0, 0, 0, 0, 0,        0, 0, 0,        0, 0, 0,       1, 3,    1, 1, 0, 0, 0,        'h8};
        tbl[9]  = '{0, 0, 0, 0, 0,        1, 3, 'h44,     0, 0, 0,       1, 3,    1, 0, 1, 3, 'h44,     'h8};
        tbl[10] = '{0, 0, 0, 0, 0,        1, 3, 'h55,     0, 0, 0,       0, 0,    1, 0, 1, 3, 'h55,     0};
        tbl[11] = '{0, 0, 1, 0, 'h1,      1, 0, 'h2,      0, 0, 0,       0, 0,    1, 0, 0, 0, 0,        0};
        tbl[12] = '{0, 0, 0, 0, 0,        0, 0, 0,        0, 0, 0,       0, 0,    0, 0, 0, 0, 0,        0};
        tbl[13] = '{0, 0, 0, 0, 0,        0, 0, 0,        0, 0, 0,       1, 9,    1, 1, 0, 0, 0,        'h200};
        tbl[14] = '{0, 0, 1, 4, 'h77,     1, 8, 'h88,     0, 0, 0,       0, 0,    1, 0, 1, 4, 'h77,     'h200};
        tbl[15] = '{0, 1, 0, 0, 0,        0, 0, 0,        1, 1, 'h99,    1, 10,   0, 0, 0, 0, 0,        0};
        tbl[16] = '{0, 0, 0, 0, 0,        0, 0, 0,        0, 0, 0,       0, 0,    1, 1, 0, 0, 0,        0};
        tbl[17] = '{0, 1, 1, 11, 'hBB,    0, 0, 0,        0, 0, 0,       0, 0,    0, 0, 1, 11, 'hBB,    0};
        tbl[18] = '{0, 0, 1, 12, 'hC,     1, 13, 'hD,     0, 0, 0,       0, 0,    1, 0, 1, 12, 'hC,     0};
        tbl[19] = '{0, 0, 1, 14, 'hE,     0, 0, 0,        0, 0, 0,       0, 0,    0, 0, 1, 14, 'hE,     0};
        tbl[20] = '{0, 0, 0, 0, 0,        0, 0, 0,        0, 0, 0,       0, 0,    0, 0, 1, 13, 'hD,     0};
        tbl[21] = '{0, 0, 1, 6, 'h66,     1, 7, 'h11,     0, 0, 0,       1, 5,    1, 0, 1, 6, 'h66,     'h20};
        tbl[22] = '{1, 0, 1, 9, 'h9,      0, 0, 0,        0, 0, 0,       1, 2,    0, 0, 0, 0, 0,        0};
        tbl[23] = '{0, 0, 0, 0, 0,        0, 0, 0,        0, 0, 0,       0, 0,    1, 1, 0, 0, 0,        0};

        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            apply_check(tbl[i]);
        end

        for (int n = 0; n < 600; n++) begin
            vec_t v;
            v.rst    = (n == 0) || ($urandom_range(0, 59) == 0);
            v.flush  = ($urandom_range(0, 19) == 0);
            v.ex_v   = ($urandom_range(0, 9) < 4);
            v.ex_rd  = 5'($urandom_range(0, 31));
            v.ex_d   = {$urandom, $urandom};
            v.mem_v  = ($urandom_range(0, 9) < 5);
            v.mem_rd = 5'($urandom_range(0, 31));
            v.mem_d  = {$urandom, $urandom};
            v.md_v   = ($urandom_range(0, 9) < 5);
            v.md_rd  = 5'($urandom_range(0, 31));
            v.md_d   = {$urandom, $urandom};
            v.iss_v  = ($urandom_range(0, 9) < 4);
            v.iss_rd = 5'($urandom_range(0, 31));
            model_step(v);
            apply_check(v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
